// File: rtl/rfarb_pkg.sv
// Shared constants and the holding-slot entry type for the register-file write arbiter.
package rfarb_pkg;
  localparam int NUM_REQ  = 3;
  localparam int REQ_JAL  = 0;
  localparam int REQ_LOAD = 1;
  localparam int REQ_ALU  = 2;

  localparam int REG_W  = 5;
  localparam int DATA_W = 32;
  localparam int AGE_W  = 2;

  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic              valid;
    logic [REG_W-1:0]  dst;
    logic [DATA_W-1:0] data;
    logic [AGE_W-1:0]  age;
  } slot_t;
endpackage

// File: rtl/rfarb_slot.sv
// One requester holding slot: load on handshake, free on grant, optional wait-age counter.
// Aging is built only when RFARB_AGE_EN is defined.
module rfarb_slot
  import rfarb_pkg::*;
#(
  parameter int AGE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              grant,
  input  logic [REG_W-1:0]  load_reg,
  input  logic [DATA_W-1:0] load_data,
  output slot_t             entry,
  output logic              aged
);
  logic              occ_q, occ_d;
  logic [REG_W-1:0]  dst_q, dst_d;
  logic [DATA_W-1:0] data_q, data_d;

  // A reload in the same edge as a grant keeps the slot occupied with the new entry.
  always_comb begin
    occ_d  = occ_q;
    dst_d  = dst_q;
    data_d = data_q;
    if (load) begin
      occ_d  = 1'b1;
      dst_d  = load_reg;
      data_d = load_data;
    end else if (grant) begin
      occ_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) occ_q <= 1'b0;
    else     occ_q <= occ_d;
  end

  always_ff @(posedge clk) begin
    dst_q  <= dst_d;
    data_q <= data_d;
  end

`ifdef RFARB_AGE_EN
  localparam logic [AGE_W-1:0] AGE_SAT = AGE_W'(AGE_LIMIT);

  logic [AGE_W-1:0] age_q, age_d;

  always_comb begin
    age_d = age_q;
    if (load || grant || !occ_q) age_d = '0;
    else if (age_q != AGE_SAT)   age_d = age_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) age_q <= '0;
    else     age_q <= age_d;
  end

  assign aged = occ_q && (age_q == AGE_SAT);
`else
  logic [AGE_W-1:0] age_q;
  assign age_q = '0;
  assign aged  = 1'b0;
`endif

  always_comb begin
    entry.valid = occ_q;
    entry.dst   = dst_q;
    entry.data  = data_q;
    entry.age   = age_q;
  end
endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates JAL/load/ALU writebacks into one registered register-file write port.
// Age-based starvation override is enabled with the RFARB_AGE_EN macro.
module regfile_write_arbiter
  import rfarb_pkg::*;
#(
  parameter int AGE_LIMIT = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*REG_W-1:0]    req_reg,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic                        wr_en,
  output logic [REG_W-1:0]            wr_reg,
  output logic [DATA_W-1:0]           wr_data,
  output logic [31:0]                 pending,
  output logic                        idle
);
  slot_t              entry [NUM_REQ];
  logic [NUM_REQ-1:0] occ, aged, grant, load;

  logic              wr_en_q, wr_en_d;
  logic [REG_W-1:0]  wr_reg_q, wr_reg_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;

  assign req_ready = rst ? '0 : (~occ | grant);
  assign load      = req_valid & req_ready;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
    rfarb_slot #(.AGE_LIMIT(AGE_LIMIT)) u_slot (
      .clk       (clk),
      .rst       (rst),
      .load      (load[i]),
      .grant     (grant[i]),
      .load_reg  (req_reg[REG_W*i +: REG_W]),
      .load_data (req_data[DATA_W*i +: DATA_W]),
      .entry     (entry[i]),
      .aged      (aged[i])
    );
    assign occ[i] = entry[i].valid;
  end

  // Aged slots win first (never set without aging), then fixed priority 0 > 1 > 2.
  always_comb begin
    logic found;
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && aged[i]) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && occ[i]) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  always_comb begin
    wr_en_d   = 1'b0;
    wr_reg_d  = wr_reg_q;
    wr_data_d = wr_data_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        wr_en_d   = (entry[i].dst != REG_ZERO);
        wr_reg_d  = entry[i].dst;
        wr_data_d = entry[i].data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_q   <= 1'b0;
      wr_reg_q  <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_reg_q  <= wr_reg_d;
      wr_data_q <= wr_data_d;
    end
  end

  // Register 0 is hard-wired, so it is never reported as in flight.
  always_comb begin
    pending = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (entry[i].valid) pending[entry[i].dst] = 1'b1;
    end
    if (wr_en_q) pending[wr_reg_q] = 1'b1;
    pending[0] = 1'b0;
  end

  assign wr_en   = wr_en_q;
  assign wr_reg  = wr_reg_q;
  assign wr_data = wr_data_q;
  assign idle    = ~|occ && !wr_en_q;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed self-checking bench for regfile_write_arbiter; starvation expectations follow RFARB_AGE_EN.
module tb_regfile_write_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [14:0] req_reg;
  logic [95:0] req_data;
  logic        wr_en;
  logic [4:0]  wr_reg;
  logic [31:0] wr_data;
  logic [31:0] pending;
  logic        idle;

  int checks = 0;
  int errors = 0;
  int first7;

  regfile_write_arbiter #(.AGE_LIMIT(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_reg   (req_reg),
    .req_data  (req_data),
    .wr_en     (wr_en),
    .wr_reg    (wr_reg),
    .wr_data   (wr_data),
    .pending   (pending),
    .idle      (idle)
  );

  always #5 clk = ~clk;

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [4:0] r, input logic [31:0] d);
    req_valid[i]       = v;
    req_reg[5*i +: 5]  = r;
    req_data[32*i +: 32] = d;
  endtask

  task automatic clear_reqs();
    req_valid = '0;
    req_reg   = '0;
    req_data  = '0;
  endtask

  initial begin
    rst = 1'b1;
    clear_reqs();
    next();
    next();
    settle();
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_wr_en", 32'(wr_en), 32'h0);
    chk("rst_wr_reg", 32'(wr_reg), 32'h0);
    chk("rst_wr_data", wr_data, 32'h0);
    chk("rst_pending", pending, 32'h0);
    chk("rst_idle", 32'(idle), 32'h1);
    rst = 1'b0;
    next();

    // Single write from the ALU requester
    set_req(2, 1'b1, 5'd5, 32'h1234);
    settle();
    chk("single_ready_c0", 32'(req_ready), 32'h7);
    next();
    clear_reqs();
    settle();
    chk("single_pending_c1", pending, 32'h20);
    chk("single_wr_en_c1", 32'(wr_en), 32'h0);
    next();
    settle();
    chk("single_wr_en_c2", 32'(wr_en), 32'h1);
    chk("single_wr_reg_c2", 32'(wr_reg), 32'd5);
    chk("single_wr_data_c2", wr_data, 32'h1234);
    chk("single_pending_c2", pending, 32'h20);
    next();
    settle();
    chk("single_wr_en_c3", 32'(wr_en), 32'h0);
    chk("single_hold_reg_c3", 32'(wr_reg), 32'd5);
    chk("single_pending_c3", pending, 32'h0);
    chk("single_idle_c3", 32'(idle), 32'h1);
    next();

    // Three simultaneous requests drain in fixed priority order
    set_req(0, 1'b1, 5'd31, 32'hAAAA_0001);
    set_req(1, 1'b1, 5'd8,  32'hBBBB_0002);
    set_req(2, 1'b1, 5'd9,  32'hCCCC_0003);
    next();
    clear_reqs();
    settle();
    chk("sim_ready_c1", 32'(req_ready), 32'h1);
    chk("sim_pending_c1", pending, 32'h8000_0300);
    chk("sim_wr_en_c1", 32'(wr_en), 32'h0);
    next();
    settle();
    chk("sim_ready_c2", 32'(req_ready), 32'h3);
    chk("sim_wr_en_c2", 32'(wr_en), 32'h1);
    chk("sim_wr_reg_c2", 32'(wr_reg), 32'd31);
    chk("sim_wr_data_c2", wr_data, 32'hAAAA_0001);
    next();
    settle();
    chk("sim_ready_c3", 32'(req_ready), 32'h7);
    chk("sim_wr_reg_c3", 32'(wr_reg), 32'd8);
    chk("sim_wr_data_c3", wr_data, 32'hBBBB_0002);
    next();
    settle();
    chk("sim_wr_en_c4", 32'(wr_en), 32'h1);
    chk("sim_wr_reg_c4", 32'(wr_reg), 32'd9);
    chk("sim_wr_data_c4", wr_data, 32'hCCCC_0003);
    next();
    settle();
    chk("sim_idle_c5", 32'(idle), 32'h1);
    next();

    // Writes to register 0 are consumed silently
    set_req(1, 1'b1, 5'd0, 32'hFFFF_FFFF);
    next();
    clear_reqs();
    settle();
    chk("zero_pending_c1", pending, 32'h0);
    chk("zero_idle_c1", 32'(idle), 32'h0);
    next();
    settle();
    chk("zero_wr_en_c2", 32'(wr_en), 32'h0);
    chk("zero_pending_c2", pending, 32'h0);
    chk("zero_wr_data_c2", wr_data, 32'hFFFF_FFFF);
    chk("zero_idle_c2", 32'(idle), 32'h1);
    next();

    // Starvation: JAL requester hammers every cycle, ALU requests once
    first7 = -1;
    for (int c = 0; c < 9; c++) begin
      set_req(0, 1'b1, 5'd1, 32'(c));
      set_req(2, (c == 0), 5'd7, 32'h77);
      settle();
      if (c >= 2 && wr_en === 1'b1 && wr_reg === 5'd7 && first7 < 0) first7 = c;
      next();
    end
    clear_reqs();
`ifdef RFARB_AGE_EN
    chk("starve_first_write_cycle", 32'(first7), 32'd5);
`else
    chk("starve_never_written", 32'(first7), 32'hFFFF_FFFF);
`endif
    next();
    next();
    next();
    next();
    settle();
    chk("starve_drained_idle", 32'(idle), 32'h1);
    next();

    // Reset in the middle of operation discards held entries
    set_req(0, 1'b1, 5'd3, 32'h3);
    set_req(1, 1'b1, 5'd4, 32'h4);
    set_req(2, 1'b1, 5'd6, 32'h6);
    next();
    rst = 1'b1;
    set_req(0, 1'b1, 5'd10, 32'h10);
    set_req(1, 1'b1, 5'd11, 32'h11);
    set_req(2, 1'b1, 5'd12, 32'h12);
    settle();
    chk("mid_rst_ready", 32'(req_ready), 32'h0);
    chk("mid_rst_wr_en_c1", 32'(wr_en), 32'h0);
    next();
    rst = 1'b0;
    clear_reqs();
    settle();
    chk("mid_rst_pending", pending, 32'h0);
    chk("mid_rst_idle", 32'(idle), 32'h1);
    chk("mid_rst_wr_reg", 32'(wr_reg), 32'h0);
    chk("mid_rst_wr_data", wr_data, 32'h0);
    for (int k = 0; k < 3; k++) begin
      next();
      settle();
      chk("mid_rst_no_write", 32'(wr_en), 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 The block SHALL have parameter AGE_LIMIT, default 3, giving the wait cycles before an occupied slot gains top priority (legal range 1..3).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, a synchronous active-high reset.
REQ-004 The block SHALL have port req_valid, input, 3, one request bit per requester: 0=JAL link, 1=load writeback, 2=ALU writeback.
REQ-005 The block SHALL have port req_ready, output, 3, one accept bit per requester.
REQ-006 The block SHALL have port req_reg, input, 15, the 5-bit destination register per requester, where requester i uses bits [5i+4:5i].
REQ-007 The block SHALL have port req_data, input, 96, the 32-bit write data per requester, where requester i uses bits [32i+31:32i].
REQ-008 The block SHALL have port wr_en, output, 1, the registered register-file write enable.
REQ-009 The block SHALL have port wr_reg, output, 5, the registered write address.
REQ-010 The block SHALL have port wr_data, output, 32, the registered write data.
REQ-011 The block SHALL have port pending, output, 32, one bit per register with a write still in flight, for decode stall.
REQ-012 The block SHALL have port idle, output, 1, high when all slots are empty and wr_en is 0.

Function
REQ-013 The block SHALL keep one holding slot per requester (occupied flag, reg, data, age).
REQ-014 req_ready[i] SHALL be high when slot i is empty or slot i is granted this cycle, and low while rst is high.
REQ-015 A handshake SHALL occur when req_valid[i] and req_ready[i] are both high, and slot i SHALL load at that edge, giving age 0.
REQ-016 Each cycle the block SHALL grant at most one occupied slot using this priority:
- any slot with age==AGE_LIMIT wins, lowest index first;
- otherwise fixed priority 0 > 1 > 2.
REQ-017 At the edge ending a grant cycle, the granted slot SHALL empty unless it reloads in the same edge, and wr_reg/wr_data SHALL load from it.
REQ-018 wr_en SHALL be 1 in the cycle after a grant when the granted reg is not 0.
REQ-019 Handshake-to-wr_en latency SHALL be 2 cycles minimum, and throughput SHALL be 1 write per cycle.
REQ-020 A granted entry targeting reg 0 SHALL consume its grant with wr_en=0, so reg 0 is never written.
REQ-021 Each occupied, non-granted slot SHALL increment its age, saturating at AGE_LIMIT.
REQ-022 pending[r] SHALL be high when any occupied slot targets r or (wr_en and wr_reg==r), and pending[0] SHALL always be 0.
REQ-023 When slots target the same reg, writes SHALL occur in grant order; the block does not reorder beyond REQ-016.
REQ-024 With no occupied slot, wr_en SHALL be 0 and wr_reg/wr_data SHALL hold their values.

Reset
REQ-025 When rst is high at an edge, the block SHALL clear every slot (occupied=0, age=0) and set wr_en=0, wr_reg=0 and wr_data=0, so pending=0 and idle=1.
REQ-026 A reset mid-operation SHALL discard held entries without writing them, and handshakes in the reset cycle SHALL not occur.

Configuration
REQ-027 With macro RFARB_AGE_EN defined, the age counters and the priority override of REQ-016/REQ-021 SHALL be present.
REQ-028 Without RFARB_AGE_EN, the block SHALL use pure fixed priority 0 > 1 > 2, SHALL not instantiate age storage, and SHALL ignore AGE_LIMIT.

Structure
REQ-029 Package rfarb_pkg SHALL hold:
- requester index constants REQ_JAL=0, REQ_LOAD=1, REQ_ALU=2;
- NUM_REQ=3;
- REG_ZERO=5'd0;
- the slot entry typedef (valid, reg, data, age).
REQ-030 One sub-module, rfarb_slot, SHALL implement a holding slot with load, grant-free and age logic, instantiated 3 times.

Verification
REQ-031 Single write: req 2 valid, reg=5, data=0x1234 at cycle 0 -> wr_en=1, wr_reg=5, wr_data=0x1234 in cycle 2; pending[5] high in cycles 1-2.
REQ-032 Simultaneous requests: all 3 valid in cycle 0, regs 31/8/9 -> writes to 31, 8, 9 in cycles 2, 3, 4; req_ready for requesters 1 and 2 low until each is granted.
REQ-033 Zero drop: req 1 writes reg 0, data 0xFFFFFFFF -> wr_en stays 0 and pending stays 0.
REQ-034 Starvation test: req 0 valid every cycle, req 2 valid in cycle 0, RFARB_AGE_EN defined, AGE_LIMIT=3 -> slot 2 granted in cycle 4, write seen in cycle 5. Without the macro, req 2 is never written while req 0 stays valid.
REQ-035 Mid-operation reset: three slots occupied, rst pulsed for 1 cycle -> wr_en never asserts for those entries, and pending=0 and idle=1 the cycle after reset.
